// File: rtl/cordic_result_collector.sv
// In-order result collector for the CORDIC engine return path: reserves a slot per
// issued request, pairs returns with the oldest pending mode, and grants issue credits.
// Optional watchdog built when CORDIC_COLLECT_TIMEOUT_EN is defined (drives err_timeout).
module cordic_result_collector #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int MODE_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic [MODE_W-1:0]         req_mode,
    output logic                      req_ready,
    input  logic                      eng_valid,
    input  logic [DATA_W-1:0]         eng_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MODE_W-1:0]         out_mode,
    output logic [DATA_W-1:0]         out_result,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      err_orphan,
    output logic                      err_overrun,
    output logic                      err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [MODE_W-1:0] slot_mode   [DEPTH];
    logic [DATA_W-1:0] slot_result [DEPTH];
    logic [DEPTH-1:0]  slot_done;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] rd_idx;

    logic accept;
    logic ret_hit;
    logic pop;

    assign wr_idx   = wr_ptr[AW-1:0];
    assign fill_idx = fill_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];

    // Credits come only from registered pointers, so a same-cycle pop never frees a slot early.
    assign level     = wr_ptr - rd_ptr;
    assign req_ready = (level < PW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign ret_hit   = eng_valid && (fill_ptr != wr_ptr);
    assign out_valid = (rd_ptr != fill_ptr) && slot_done[rd_idx];
    assign pop       = out_valid && out_ready;

    // Slot contents are not reset; gating keeps stale data off the outputs after reset.
    assign out_mode   = out_valid ? slot_mode[rd_idx]   : '0;
    assign out_result = out_valid ? slot_result[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_mode[wr_idx] <= req_mode;
            slot_done[wr_idx] <= 1'b0;
        end
        if (ret_hit) begin
            slot_result[fill_idx] <= eng_result;
            slot_done[fill_idx]   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            err_orphan  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ret_hit) begin
                fill_ptr <= fill_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (eng_valid && !ret_hit) begin
                err_orphan <= 1'b1;
            end
            if (req_valid && !req_ready) begin
                err_overrun <= 1'b1;
            end
        end
    end

`ifdef CORDIC_COLLECT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;
    logic            err_timeout_q;

    // Runs only while the oldest reserved slot is still waiting on the engine.
    assign wd_run      = (fill_ptr != wr_ptr) && !eng_valid;
    assign err_timeout = err_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (!wd_run) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_run && (wd_cnt == WD_W'(TIMEOUT - 1))) begin
                err_timeout_q <= 1'b1;
            end
        end
    end
`else
    // No watchdog in this build; TIMEOUT is a legal positive value, so this is constant low.
    assign err_timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_cordic_result_collector.sv
// Directed bench for cordic_result_collector: in-order pairing, credits, errors, reset.
module tb_cordic_result_collector;
    localparam int DEPTH   = 8;
    localparam int DATA_W  = 32;
    localparam int MODE_W  = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic [MODE_W-1:0] req_mode = '0;
    logic              req_ready;
    logic              eng_valid = 1'b0;
    logic [DATA_W-1:0] eng_result = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MODE_W-1:0] out_mode;
    logic [DATA_W-1:0] out_result;
    logic [3:0]        level;
    logic              err_orphan;
    logic              err_overrun;
    logic              err_timeout;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cordic_result_collector #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .MODE_W(MODE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
        .eng_valid(eng_valid), .eng_result(eng_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .out_result(out_result),
        .level(level),
        .err_orphan(err_orphan), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_valid = 1'b0; eng_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (out_mode !== 4'd0 || out_result !== 32'd0) begin n_bad++; $display("FAIL reset_out_data got=%0h/%0h exp=0/0", out_mode, out_result); end
        n_vec++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_vec++; if ({err_orphan, err_overrun, err_timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_err got=%b exp=000", {err_orphan, err_overrun, err_timeout}); end
        rst_n = 1'b1;
        step();
        n_vec++; if (req_ready !== 1'b1 || level !== 4'd0) begin n_bad++; $display("FAIL reset_release got rdy=%b lvl=%0d exp rdy=1 lvl=0", req_ready, level); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        req_valid = 1'b1; req_mode = 4'd0; step();
        n_vec++; if (level !== 4'd1) begin n_bad++; $display("FAIL basic_level1 got=%0d exp=1", level); end
        req_mode = 4'd1; step();
        req_valid = 1'b0;
        n_vec++; if (level !== 4'd2 || out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_level2 got lvl=%0d vld=%b exp lvl=2 vld=0", level, out_valid); end
        repeat (14) step();
        eng_valid = 1'b1; eng_result = 32'd32768; step();
        n_vec++; if (out_valid !== 1'b1 || out_mode !== 4'd0 || out_result !== 32'd32768) begin n_bad++; $display("FAIL basic_first got vld=%b %0d/%0d exp 1 0/32768", out_valid, out_mode, out_result); end
        n_vec++; if (level !== 4'd2) begin n_bad++; $display("FAIL basic_level_ret got=%0d exp=2", level); end
        eng_result = 32'd56756; step();
        eng_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_mode !== 4'd1 || out_result !== 32'd56756) begin n_bad++; $display("FAIL basic_second got vld=%b %0d/%0d exp 1 1/56756", out_valid, out_mode, out_result); end
        n_vec++; if (level !== 4'd1) begin n_bad++; $display("FAIL basic_level_pop1 got=%0d exp=1", level); end
        step();
        n_vec++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain got lvl=%0d vld=%b exp 0 0", level, out_valid); end
    endtask

    task automatic test_full_overrun();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL full_credit_%0d got=%b exp=1", i, req_ready); end
            req_valid = 1'b1; req_mode = 4'(i); step();
        end
        req_valid = 1'b0;
        n_vec++; if (req_ready !== 1'b0 || level !== 4'd8) begin n_bad++; $display("FAIL full_ready got rdy=%b lvl=%0d exp 0 8", req_ready, level); end
        for (int i = 0; i < DEPTH; i++) begin
            eng_valid = 1'b1; eng_result = 32'h100 + 32'(i); step();
        end
        eng_valid = 1'b0;
        req_valid = 1'b1; req_mode = 4'hF; step();
        req_valid = 1'b0;
        n_vec++; if (err_overrun !== 1'b1 || level !== 4'd8) begin n_bad++; $display("FAIL overrun got err=%b lvl=%0d exp 1 8", err_overrun, level); end
        n_vec++; if (out_mode !== 4'd0) begin n_bad++; $display("FAIL overrun_no_write got mode=%0h exp=0", out_mode); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++; if (out_valid !== 1'b1 || out_mode !== 4'(i) || out_result !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL full_pop_%0d got vld=%b %0h/%0h exp 1 %0h/%0h", i, out_valid, out_mode, out_result, i, 32'h100 + 32'(i)); end
            step();
        end
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || level !== 4'd0) begin n_bad++; $display("FAIL full_drained got vld=%b lvl=%0d exp 0 0", out_valid, level); end
    endtask

    task automatic test_full_pop_refill();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            req_valid = 1'b1; req_mode = 4'(8 + i); step();
        end
        req_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            eng_valid = 1'b1; eng_result = 32'h200 + 32'(i); step();
        end
        eng_valid = 1'b0;
        n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL refill_full got rdy=%b exp=0", req_ready); end
        out_ready = 1'b1; req_valid = 1'b1; req_mode = 4'h3;
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++; if (out_valid !== 1'b1 || out_mode !== 4'(8 + i) || out_result !== 32'h200 + 32'(i)) begin n_bad++; $display("FAIL refill_pop_%0d got vld=%b %0h/%0h exp 1 %0h/%0h", i, out_valid, out_mode, out_result, 8 + i, 32'h200 + 32'(i)); end
            step();
            n_vec++; if (req_ready !== 1'b1 || level !== 4'd7) begin n_bad++; $display("FAIL refill_level_%0d got rdy=%b lvl=%0d exp 1 7", i, req_ready, level); end
        end
        req_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL refill_pending got vld=%b exp=0", out_valid); end
        for (int i = 0; i < 7; i++) begin
            eng_valid = 1'b1; eng_result = 32'h300 + 32'(i); step();
            n_vec++; if (out_valid !== 1'b1 || out_mode !== 4'h3 || out_result !== 32'h300 + 32'(i)) begin n_bad++; $display("FAIL refill_ret_%0d got vld=%b %0h/%0h exp 1 3/%0h", i, out_valid, out_mode, out_result, 32'h300 + 32'(i)); end
        end
        eng_valid = 1'b0; step();
        out_ready = 1'b0;
        n_vec++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL refill_drain got lvl=%0d vld=%b exp 0 0", level, out_valid); end
    endtask

    task automatic test_orphan();
        n_vec++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL orphan_pre got=%b exp=0", err_orphan); end
        eng_valid = 1'b1; eng_result = 32'h12345678; step();
        eng_valid = 1'b0;
        n_vec++; if (err_orphan !== 1'b1 || out_valid !== 1'b0 || level !== 4'd0) begin n_bad++; $display("FAIL orphan got err=%b vld=%b lvl=%0d exp 1 0 0", err_orphan, out_valid, level); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_mode = 4'(5 + i); step();
        end
        req_valid = 1'b0;
        eng_valid = 1'b1; eng_result = 32'hABCD; step();
        eng_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_mode !== 4'd5 || level !== 4'd3) begin n_bad++; $display("FAIL arst_pre got vld=%b mode=%0h lvl=%0d exp 1 5 3", out_valid, out_mode, level); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_mode !== 4'd0 || out_result !== 32'd0) begin n_bad++; $display("FAIL arst_out got vld=%b %0h/%0h exp 0 0/0", out_valid, out_mode, out_result); end
        n_vec++; if (req_ready !== 1'b1 || level !== 4'd0) begin n_bad++; $display("FAIL arst_level got rdy=%b lvl=%0d exp 1 0", req_ready, level); end
        n_vec++; if ({err_orphan, err_overrun, err_timeout} !== 3'b000) begin n_bad++; $display("FAIL arst_err got=%b exp=000", {err_orphan, err_overrun, err_timeout}); end
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
        n_vec++; if (err_orphan !== 1'b0) begin n_bad++; $display("FAIL arst_release got orphan=%b exp=0", err_orphan); end
        eng_valid = 1'b1; eng_result = 32'h1111; step();
        eng_result = 32'h2222; step();
        eng_valid = 1'b0;
        n_vec++; if (err_orphan !== 1'b1 || out_valid !== 1'b0 || level !== 4'd0) begin n_bad++; $display("FAIL arst_inflight got err=%b vld=%b lvl=%0d exp 1 0 0", err_orphan, out_valid, level); end
    endtask

    task automatic test_same_cycle_orphan();
        apply_reset();
        req_valid = 1'b1; req_mode = 4'd9; eng_valid = 1'b1; eng_result = 32'h55; step();
        req_valid = 1'b0;
        n_vec++; if (err_orphan !== 1'b1 || level !== 4'd1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL same_cycle got err=%b lvl=%0d vld=%b exp 1 1 0", err_orphan, level, out_valid); end
        eng_result = 32'h66; step();
        eng_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_mode !== 4'd9 || out_result !== 32'h66) begin n_bad++; $display("FAIL same_cycle_ret got vld=%b %0h/%0h exp 1 9/66", out_valid, out_mode, out_result); end
        out_ready = 1'b1; step();
        out_ready = 1'b0;
        n_vec++; if (level !== 4'd0) begin n_bad++; $display("FAIL same_cycle_drain got lvl=%0d exp=0", level); end
    endtask

    task automatic test_timeout();
        logic exp_to;
`ifdef CORDIC_COLLECT_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        apply_reset();
        req_valid = 1'b1; req_mode = 4'd2; step();
        req_valid = 1'b0;
        repeat (TIMEOUT - 1) step();
        n_vec++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_early got=%b exp=0", err_timeout); end
        step();
        n_vec++; if (err_timeout !== exp_to) begin n_bad++; $display("FAIL timeout_hit got=%b exp=%b", err_timeout, exp_to); end
        repeat (8) step();
        n_vec++; if (err_timeout !== exp_to) begin n_bad++; $display("FAIL timeout_sticky got=%b exp=%b", err_timeout, exp_to); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overrun();
        test_full_pop_refill();
        test_orphan();
        test_async_reset();
        test_same_cycle_orphan();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cordic_result_collector.md
# cordic_result_collector

In-order result collector on the return side of the CORDIC engine. It reserves a buffer slot for every request the issuer sends (`pre_valid`/`mode` toward `cordic_top`). It pairs each returning `post_valid`/`result` with the mode of the oldest outstanding request, then presents `{mode, result}` to the consumer on a valid/ready interface. The CORDIC pipeline has no backpressure, so the block grants issue credits that guarantee no result is ever dropped.

## Interface
- `DEPTH`, 8: slots, power of 2, 2..64.
- `DATA_W`, 32: result width (Q16.16 signed).
- `MODE_W`, 4: mode tag width.
- `TIMEOUT`, 64: watchdog limit in cycles. Used only with the watchdog macro.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request issued to the engine; wired in parallel with engine `pre_valid`.
- `req_mode` in MODE_W: mode of that request.
- `req_ready` out 1: credit available; the issuer may assert `req_valid` only while this is high.
- `eng_valid` in 1: engine `post_valid`.
- `eng_result` in DATA_W: engine `result`.
- `out_valid` out 1: head entry complete.
- `out_ready` in 1: consumer accepts.
- `out_mode` out MODE_W: mode of head entry.
- `out_result` out DATA_W: result of head entry.
- `level` out $clog2(DEPTH)+1: occupied slots, counting pending and complete.
- `err_orphan` out 1: sticky; `eng_valid` arrived with no pending slot.
- `err_overrun` out 1: sticky; `req_valid` arrived while `req_ready` was low.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- Slot array of DEPTH entries, each holding `{mode, result, done}`.
- Three pointers, each $clog2(DEPTH)+1 bits with a wrap bit: `wr` (reserve), `fill` (next pending), `rd` (head).
- Accept (`req_valid && req_ready`): write `req_mode` at `wr`, clear `done`, increment `wr`.
- Return (`eng_valid`):
  - If `fill != wr`: store `eng_result` at `fill`, set `done`, increment `fill`.
  - Otherwise: drop the result and set `err_orphan`.
- Pop (`out_valid && out_ready`): increment `rd`.
- `req_ready = (level < DEPTH)`, combinational from registered pointers. An accept while full is ignored (no slot written) and sets `err_overrun`.
- `out_valid = (rd != fill)`. This is equivalent to the head slot having `done` set.
- `out_mode` and `out_result` are read from slot `rd`. They hold stable while `out_valid && !out_ready`.
- Accept, return and pop may all occur in the same cycle. `level` updates by (+accept − pop).
- Results are strictly in order. Mode values are opaque tags and are never decoded.

## Timing
- Reset values:
  - `req_ready`=1
  - `out_valid`=0
  - `out_mode`=0
  - `out_result`=0
  - `level`=0
  - all `err_*`=0
  - all pointers=0
  - slot contents don't-care
- Reset mid-operation discards every slot immediately. Engine results still in flight after reset release raise `err_orphan`, so the engine must share `rst_n`.
- `eng_valid` at edge N with the head slot pending gives `out_valid`=1 after edge N, with zero added pipeline delay.
- Pop at edge N shows the next head after edge N. `out_valid` can stay high back-to-back at one result per cycle.
- `req_ready` falls in the cycle after the accept that fills the last slot. It rises in the cycle after the pop that frees a slot.
- Full, with simultaneous pop and `req_valid`: the request is refused, because `req_ready` reflects the pre-pop level. No same-cycle bypass.
- Empty, with simultaneous accept and `eng_valid`: the result is orphaned. The new slot is not eligible until the next cycle, and engine latency is always ≥1.

## Configuration
- `CORDIC_COLLECT_TIMEOUT_EN` defined:
  - A watchdog counter runs while `level>0` and the slot at `fill` is pending.
  - The counter clears on every return and whenever `fill == wr`.
  - When it reaches `TIMEOUT`, `err_timeout` sets (sticky until reset) and the counter saturates.
- Not defined: no counter is built and `err_timeout` is tied to 0.

## Test plan
1. Reset release, then accept mode 0 and mode 1 on consecutive cycles. Model returns 32768 then 56756 (sin30 and sin60, Q16.16) 16 cycles later. Required: `out_mode`/`out_result` = 0/32768 then 1/56756, `level` 2→0.
2. `out_ready`=0, issue 8 requests (DEPTH=8) with results returned. Required: `req_ready`=0 after the 8th accept. A 9th `req_valid` sets `err_overrun` and `level` stays 8. Raise `out_ready`: 8 consecutive pops with `out_valid` high every cycle.
3. Full buffer with `out_ready`=1 and `req_valid` held. Required: one pop per cycle, and `req_ready` reasserts the cycle after the first pop.
4. `eng_valid` with `result`=0x12345678 and no outstanding request. Required: `err_orphan`=1, `out_valid`=0, `level`=0.
5. Assert `rst_n`=0 with 3 slots occupied mid-stream. Required: all outputs at reset values asynchronously. Two post-reset engine returns set `err_orphan`.
6. With `CORDIC_COLLECT_TIMEOUT_EN` and `TIMEOUT`=64, accept one request and never return it. Required: `err_timeout` rises on cycle 64. Without the macro, `err_timeout` stays 0.
